spi_slave_mem: RTL

Responder end of the team's SPI link: an SPI mode-0 slave that turns master frames into word reads and writes on a local byte-addressed memory port. One instance sits behind each slave select (one of up to four) and fronts that slave's 32x1024 memory. The block oversamples SCLK/MOSI/CS_N with the system clock, decodes a command/address header and runs single or burst word transfers.

---
 rtl/spi_slave_mem.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_mem.sv
// SPI mode-0 slave bridging master frames to word reads/writes on a local memory port.
// Inputs are oversampled through 2-FF synchronizers; 8-bit command, 16-bit address, 32-bit bursts.
module spi_slave_mem #(
    parameter int AWIDTH = 15,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WR_DATA, RD_FETCH, RD_DATA, IGNORE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic              sclk_prev_q;
    logic [4:0]        cnt_q, cnt_d;
    logic [DWIDTH-1:0] rx_q, rx_d, tx_q, tx_d, wdata_q, wdata_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              we_q, we_d, re_q, re_d;
    logic              miso_q, miso_d, oe_q, oe_d;
    logic              busy_q, busy_d, err_q, err_d;

    logic              sclk_s, cs_s, mosi_s, rise, fall;
    logic [DWIDTH-1:0] rx_next;

    assign sclk_s  = sclk_sync_q[1];
    assign cs_s    = cs_sync_q[1];
    assign mosi_s  = mosi_sync_q[1];
    assign rise    = sclk_s & ~sclk_prev_q;
    assign fall    = ~sclk_s & sclk_prev_q;
    assign rx_next = {rx_q[DWIDTH-2:0], mosi_s};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        miso_d  = miso_q;
        oe_d    = oe_q;
        err_d   = 1'b0;
        // Deselect wins over everything; partial words are simply dropped.
        if (cs_s && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
            miso_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!cs_s) begin
                        state_d = CMD;
                        cnt_d   = '0;
                    end
                end
                CMD: begin
                    if (rise) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d = '0;
                            if (rx_next[7:0] == 8'h02) begin
                                state_d = ADDR;
                                rd_d    = 1'b0;
                            end else if (rx_next[7:0] == 8'h03) begin
                                state_d = ADDR;
                                rd_d    = 1'b1;
                            end else begin
                                state_d = IGNORE;
                                err_d   = 1'b1;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (rise) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd15) begin
                            cnt_d  = '0;
                            addr_d = {rx_next[AWIDTH-1:2], 2'b00};
                            if (rd_q) begin
                                state_d = RD_FETCH;
                                re_d    = 1'b1;
                            end else begin
                                state_d = WR_DATA;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (we_q)
                        addr_d = addr_q + AWIDTH'(4);
                    if (rise) begin
                        rx_d  = rx_next;
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            cnt_d   = '0;
                            we_d    = 1'b1;
                            wdata_d = rx_next;
                        end
                    end
                end
                RD_FETCH: begin
                    // First cycle is the strobe; rdata is valid the cycle after.
                    if (!re_q) begin
                        tx_d    = mem_rdata;
                        oe_d    = 1'b1;
                        state_d = RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (fall) begin
                        miso_d = tx_q[DWIDTH-1];
                        tx_d   = {tx_q[DWIDTH-2:0], 1'b0};
                    end
                    if (rise) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            cnt_d   = '0;
                            addr_d  = addr_q + AWIDTH'(4);
                            re_d    = 1'b1;
                            state_d = RD_FETCH;
                        end
                    end
                end
                IGNORE: begin
                    state_d = IGNORE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= 2'b00;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sclk_prev_q <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            wdata_q     <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            sclk_prev_q <= sclk_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            wdata_q     <= wdata_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            we_q        <= we_d;
            re_q        <= re_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_we      = we_q;
    assign mem_re      = re_q;
    assign busy        = busy_q;
    assign cmd_err     = err_q;

endmodule
